// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, 1-cycle simple ops, bit-serial MUL/DIV.
// Define ALU_SEQ_DIV_EN to build the restoring divider.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       status
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [SHW-1:0] CNT_LAST =
    SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_LIM =
    WIDTH'(WIDTH);
  localparam logic [WIDTH:0] ONE_W =
    (WIDTH+1)'(1);

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opb;

  logic op_add, op_sub, op_shl, op_shr;
  logic op_mul, op_div, op_and, op_xor;

  assign op_add = (opcode == 3'b000);
  assign op_sub = (opcode == 3'b001);
  assign op_shl = (opcode == 3'b010);
  assign op_shr = (opcode == 3'b011);
  assign op_mul = (opcode == 3'b100);
  assign op_div = (opcode == 3'b101);
  assign op_and = (opcode == 3'b110);
  assign op_xor = (opcode == 3'b111);

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [SHW-1:0]   amt;
  logic             sh_big;
  logic             sh_zero;

  assign amt     = operand2[SHW-1:0];
  assign sh_big  = (operand2 >= W_LIM);
  assign sh_zero = (operand2 == '0);

  assign add_w = {1'b0, operand1}
               + {1'b0, operand2};
  assign sub_w = {1'b0, operand1}
               + {1'b0, ~operand2}
               + ONE_W;
  // extra bit on the out-going side holds
  // the last bit shifted out
  assign shl_w = {1'b0, operand1} << amt;
  assign shr_w = {operand1, 1'b0} >> amt;

  logic [WIDTH-1:0] s_res;
  logic [WIDTH-1:0] s_hi;
  logic             s_carry;
  logic             s_err;
  logic             iter_go;

  // single-cycle results and iterate request
  always_comb begin
    s_res   = '0;
    s_hi    = '0;
    s_carry = 1'b0;
    s_err   = 1'b0;
    iter_go = 1'b0;
    unique case (1'b1)
      op_add: begin
        s_res   = add_w[WIDTH-1:0];
        s_carry = add_w[WIDTH];
      end
      op_sub: begin
        s_res   = sub_w[WIDTH-1:0];
        s_carry = ~sub_w[WIDTH];
      end
      op_shl: begin
        if (sh_zero) begin
          s_res = operand1;
        end else if (!sh_big) begin
          s_res   = shl_w[WIDTH-1:0];
          s_carry = shl_w[WIDTH];
        end
      end
      op_shr: begin
        if (sh_zero) begin
          s_res = operand1;
        end else if (!sh_big) begin
          s_res   = shr_w[WIDTH:1];
          s_carry = shr_w[0];
        end
      end
      op_mul: begin
        iter_go = 1'b1;
      end
      op_div: begin
`ifdef ALU_SEQ_DIV_EN
        if (sh_zero) begin
          s_res = '1;
          s_hi  = operand1;
          s_err = 1'b1;
        end else begin
          iter_go = 1'b1;
        end
`else
        s_err = 1'b1;
`endif
      end
      op_and: begin
        s_res = operand1 & operand2;
      end
      op_xor: begin
        s_res = operand1 ^ operand2;
      end
      default: begin
        s_res = '0;
      end
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mq;

  assign mul_sum = {1'b0, acc}
    + (mq[0] ? {1'b0, opb} : '0);
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_mq  = {mul_sum[0],
                    mq[WIDTH-1:1]};

  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_mq;
  logic             fin_carry;

`ifdef ALU_SEQ_DIV_EN
  logic             is_div;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_mq;

  // remainder stays below the divisor, so
  // the low WIDTH bits of the difference
  // are exact
  assign div_sh  = {acc, mq[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opb});
  assign div_acc = div_ge
    ? div_sh[WIDTH-1:0] - opb
    : div_sh[WIDTH-1:0];
  assign div_mq  = {mq[WIDTH-2:0], div_ge};

  assign nxt_acc   = is_div ? div_acc
                            : mul_acc;
  assign nxt_mq    = is_div ? div_mq
                            : mul_mq;
  assign fin_carry = ~is_div
                   & (nxt_acc != '0);
`else
  assign nxt_acc   = mul_acc;
  assign nxt_mq    = mul_mq;
  assign fin_carry = (nxt_acc != '0);
`endif

  // control FSM, iteration datapath and
  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mq        <= '0;
      opb       <= '0;
`ifdef ALU_SEQ_DIV_EN
      is_div    <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      status    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (iter_go) begin
            state  <= ITER;
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mq     <= operand1;
            opb    <= operand2;
`ifdef ALU_SEQ_DIV_EN
            is_div <= op_div;
`endif
          end else begin
            done      <= 1'b1;
            result    <= s_res;
            result_hi <= s_hi;
            status    <= {s_err,
                          s_res[WIDTH-1],
                          s_res == '0,
                          s_carry};
          end
        end
      end else begin
        acc <= nxt_acc;
        mq  <= nxt_mq;
        if (cnt == CNT_LAST) begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          cnt       <= '0;
          result    <= nxt_mq;
          result_hi <= nxt_acc;
          status    <= {1'b0,
                        nxt_mq[WIDTH-1],
                        nxt_mq == '0,
                        fin_carry};
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at
// WIDTH=16, with hand-computed expectations.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic [2:0]  opcode   = 3'b000;
  logic [15:0] operand1 = 16'h0000;
  logic [15:0] operand2 = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic [3:0]  status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .status    (status)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic [2:0]  op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    start    = 1'b1;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(
    output int lat,
    output int nbusy
  );
    lat   = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic outs(
    input string       tag,
    input logic [15:0] r,
    input logic [15:0] h,
    input logic [3:0]  st
  );
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(r));
    check({tag, "_hi"}, 32'(result_hi), 32'(h));
    check({tag, "_st"}, 32'(status), 32'(st));
  endtask

  task automatic zeros(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_res"}, 32'(result), 32'd0);
    check({tag, "_hi"}, 32'(result_hi), 32'd0);
    check({tag, "_st"}, 32'(status), 32'd0);
  endtask

  task automatic single(
    input string       tag,
    input logic [2:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] r,
    input logic [15:0] h,
    input logic [3:0]  st
  );
    int lat;
    int nb;
    issue(op, a, b);
    wait_done(lat, nb);
    check({tag, "_lat"}, 32'(lat + 1), 32'd1);
    outs(tag, r, h, st);
  endtask

  task automatic multi(
    input string       tag,
    input logic [2:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] r,
    input logic [15:0] h,
    input logic [3:0]  st
  );
    int lat;
    int nb;
    issue(op, a, b);
    wait_done(lat, nb);
    check({tag, "_lat"}, 32'(lat + 1), 32'd17);
    check({tag, "_nbusy"}, 32'(nb), 32'd16);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    outs(tag, r, h, st);
  endtask

  initial begin
    int lat;
    int nb;
    int nd;

    repeat (3) @(posedge clk);
    #1;
    zeros("rst");
    rst_n = 1'b1;

    single("add", OP_ADD, 16'hFFFF, 16'h0001,
           16'h0000, 16'h0000, 4'b0011);
    @(posedge clk);
    #1;
    check("add_pulse", 32'(done), 32'd0);

    single("sub", OP_SUB, 16'h0003, 16'h0005,
           16'hFFFE, 16'h0000, 4'b0101);
    single("shl", OP_SHL, 16'h8001, 16'h0001,
           16'h0002, 16'h0000, 4'b0001);
    single("shl0", OP_SHL, 16'h8001, 16'h0000,
           16'h8001, 16'h0000, 4'b0100);
    single("shr", OP_SHR, 16'h8001, 16'd20,
           16'h0000, 16'h0000, 4'b0010);
    single("shr4", OP_SHR, 16'h8008, 16'd4,
           16'h0800, 16'h0000, 4'b0001);
    single("and", OP_AND, 16'h8F00, 16'hF0F0,
           16'h8000, 16'h0000, 4'b0100);
    single("xor", OP_XOR, 16'hF0F0, 16'hFF00,
           16'h0FF0, 16'h0000, 4'b0000);

    multi("mul1", OP_MUL, 16'h1234, 16'h0100,
          16'h3400, 16'h0012, 4'b0001);
    multi("mul2", OP_MUL, 16'hFFFF, 16'hFFFF,
          16'h0001, 16'hFFFE, 4'b0001);

`ifdef ALU_SEQ_DIV_EN
    multi("div", OP_DIV, 16'd1000, 16'd7,
          16'h008E, 16'h0006, 4'b0000);
    single("div0", OP_DIV, 16'd5, 16'd0,
           16'hFFFF, 16'h0005, 4'b1100);
`else
    single("div", OP_DIV, 16'd1000, 16'd7,
           16'h0000, 16'h0000, 4'b1010);
    single("div0", OP_DIV, 16'd5, 16'd0,
           16'h0000, 16'h0000, 4'b1010);
`endif

    issue(OP_MUL, 16'h0003, 16'h0005);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("ign_busy", 32'(busy), 32'd1);
    start    = 1'b1;
    opcode   = OP_ADD;
    operand1 = 16'h1111;
    operand2 = 16'h2222;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, nb);
    outs("ign", 16'h000F, 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    check("ign_after_done", 32'(done), 32'd0);
    check("ign_after_busy", 32'(busy), 32'd0);

    issue(OP_MUL, 16'h0007, 16'h0009);
    start    = 1'b1;
    opcode   = OP_ADD;
    operand1 = 16'h0010;
    operand2 = 16'h0020;
    wait_done(lat, nb);
    check("hold_lat", 32'(lat + 1), 32'd17);
    outs("hold_mul", 16'h003F, 16'h0000,
         4'b0000);
    @(posedge clk);
    #1;
    start = 1'b0;
    outs("hold_add", 16'h0030, 16'h0000,
         4'b0000);
    @(posedge clk);
    #1;
    check("hold_pulse", 32'(done), 32'd0);

    issue(OP_MUL, 16'h1234, 16'h0100);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    zeros("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) nd++;
    end
    check("mid_no_done", 32'(nd), 32'd0);
    check("mid_res_held", 32'(result), 32'd0);

    single("post", OP_ADD, 16'h0002, 16'h0003,
           16'h0005, 16'h0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
